rob_ring_buffer: RTL and testbench

//  Parametrised in-order-retire reorder buffer for the OoO core, sitting between Rename/Dispatch and the ARF/free list.
//  - Accepts one dispatch per cycle and tracks completion from NUM_CPL functional-unit writeback ports, tagged by ROB index.
//  - Retires up to RETIRE_W completed head entries per cycle to the ARF and rename free list.
//  - Adds configurable depth, completion-port count and retire width, plus a single-store-per-cycle retire rule.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_ring_buffer_if.sv | 58 +++++
 rtl/rob_retire_select.sv | 33 +++
 rtl/rob_ring_buffer.sv | 142 ++++++++++++++
 tb/tb_rob_ring_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Reorder-buffer shared types: entry layout and architectural register width.
// Payload widths here set the storage layout; the top defaults XLEN/PREG_W to match.
package rob_pkg;

  localparam int ARCH_REG_W = 5;
  localparam int ROB_XLEN   = 32;
  localparam int ROB_PREG_W = 6;

  typedef struct packed {
    logic [ROB_XLEN-1:0]   pc;
    logic [ARCH_REG_W-1:0] arch_rd;
    logic [ROB_PREG_W-1:0] prd;
    logic [ROB_PREG_W-1:0] old_prd;
    logic [ROB_XLEN-1:0]   data;
    logic                  has_rd;
    logic                  is_store;
    logic                  valid;
    logic                  done;
  } rob_entry_t;

endpackage

// File: rtl/rob_ring_buffer_if.sv
// Dispatch / completion / retire bundle between Rename, the FUs, the ROB and the ARF.
// master = core side driving dispatch and writeback; slave = the ROB.
interface rob_ring_buffer_if
  import rob_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_CPL  = 4,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = 6,
  parameter int XLEN     = 32
);
  localparam int ROB_W = $clog2(DEPTH);

  // Dispatch transfers on a cycle where disp_valid && disp_ready; disp_valid and
  // its payload must hold until that cycle. Completion and retire are strobes with
  // no back-pressure.
  logic                         disp_valid;
  logic                         disp_ready;
  logic [XLEN-1:0]              disp_pc;
  logic                         disp_has_rd;
  logic [ARCH_REG_W-1:0]        disp_arch_rd;
  logic [PREG_W-1:0]            disp_prd;
  logic [PREG_W-1:0]            disp_old_prd;
  logic                         disp_is_store;
  logic [ROB_W-1:0]             disp_tag;

  logic [NUM_CPL-1:0]           cpl_valid;
  logic [NUM_CPL*ROB_W-1:0]     cpl_tag;
  logic [NUM_CPL*XLEN-1:0]      cpl_data;

  logic [RETIRE_W-1:0]            ret_valid;
  logic [RETIRE_W*XLEN-1:0]       ret_pc;
  logic [RETIRE_W*ARCH_REG_W-1:0] ret_arch_rd;
  logic [RETIRE_W*PREG_W-1:0]     ret_prd;
  logic [RETIRE_W*PREG_W-1:0]     ret_old_prd;
  logic [RETIRE_W*XLEN-1:0]       ret_data;
  logic [RETIRE_W-1:0]            ret_has_rd;
  logic [RETIRE_W-1:0]            ret_is_store;

  logic [ROB_W:0]               count;
  logic                         empty;
  logic                         full;

  modport master (
    output disp_valid, disp_pc, disp_has_rd, disp_arch_rd, disp_prd, disp_old_prd,
           disp_is_store, cpl_valid, cpl_tag, cpl_data,
    input  disp_ready, disp_tag, ret_valid, ret_pc, ret_arch_rd, ret_prd, ret_old_prd,
           ret_data, ret_has_rd, ret_is_store, count, empty, full
  );

  modport slave (
    input  disp_valid, disp_pc, disp_has_rd, disp_arch_rd, disp_prd, disp_old_prd,
           disp_is_store, cpl_valid, cpl_tag, cpl_data,
    output disp_ready, disp_tag, ret_valid, ret_pc, ret_arch_rd, ret_prd, ret_old_prd,
           ret_data, ret_has_rd, ret_is_store, count, empty, full
  );

endinterface

// File: rtl/rob_retire_select.sv
// Head-window scan: picks the contiguous run of valid+done entries from the head,
// stopping at the first entry that is not ready or at a second store.
module rob_retire_select #(
  parameter int RETIRE_W = 2,
  parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
  input  logic [RETIRE_W-1:0] valid_i,
  input  logic [RETIRE_W-1:0] done_i,
  input  logic [RETIRE_W-1:0] store_i,
  output logic [RETIRE_W-1:0] ret_valid_o,
  output logic [CNT_W-1:0]    ret_cnt_o
);

  logic stop;
  logic store_seen;

  always_comb begin
    ret_valid_o = '0;
    ret_cnt_o   = '0;
    stop        = 1'b0;
    store_seen  = 1'b0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (!stop && valid_i[k] && done_i[k] && !(store_i[k] && store_seen)) begin
        ret_valid_o[k] = 1'b1;
        ret_cnt_o      = ret_cnt_o + CNT_W'(1);
        store_seen     = store_seen | store_i[k];
      end else begin
        stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_ring_buffer.sv
// In-order-retire reorder buffer: one dispatch per cycle, NUM_CPL writeback ports,
// up to RETIRE_W retirements per cycle. Define ROB_FLUSH_EN to add the flush port.
module rob_ring_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_CPL  = 4,
  parameter int RETIRE_W = 2,
  parameter int PREG_W   = ROB_PREG_W,
  parameter int XLEN     = ROB_XLEN
) (
  input  logic clk,
  input  logic rstn,
  rob_ring_buffer_if.slave rob
`ifdef ROB_FLUSH_EN
  ,
  input  logic flush
`endif
);

  localparam int ROB_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RETIRE_W + 1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [ROB_W:0]      head_q, head_d, tail_q, tail_d;
  rob_entry_t          ent_q [DEPTH];
  logic                flush_w;
  logic                disp_fire;
  logic [ROB_W-1:0]    win_idx [RETIRE_W];
  logic [RETIRE_W-1:0] win_valid, win_done, win_store;
  logic [RETIRE_W-1:0] sel_valid;
  logic [CNT_W-1:0]    sel_cnt;
  logic [RETIRE_W-1:0] ret_valid;
  logic [CNT_W-1:0]    ret_cnt;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign rob.full       = (head_q[ROB_W-1:0] == tail_q[ROB_W-1:0]) && (head_q[ROB_W] != tail_q[ROB_W]);
  assign rob.empty      = (head_q == tail_q);
  assign rob.count      = tail_q - head_q;
  assign rob.disp_ready = ~rstn & ~rob.full;
  assign rob.disp_tag   = tail_q[ROB_W-1:0];
  assign disp_fire      = rob.disp_valid & rob.disp_ready;

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      win_idx[k]   = head_q[ROB_W-1:0] + ROB_W'(k);
      win_valid[k] = ent_q[win_idx[k]].valid;
      win_done[k]  = ent_q[win_idx[k]].done;
      win_store[k] = ent_q[win_idx[k]].is_store;
    end
  end

  rob_retire_select #(.RETIRE_W(RETIRE_W), .CNT_W(CNT_W)) u_sel (
    .valid_i     (win_valid),
    .done_i      (win_done),
    .store_i     (win_store),
    .ret_valid_o (sel_valid),
    .ret_cnt_o   (sel_cnt)
  );

  assign ret_valid     = flush_w ? '0 : sel_valid;
  assign ret_cnt       = flush_w ? '0 : sel_cnt;
  assign rob.ret_valid = ret_valid;

  always_comb begin
    rob.ret_pc       = '0;
    rob.ret_arch_rd  = '0;
    rob.ret_prd      = '0;
    rob.ret_old_prd  = '0;
    rob.ret_data     = '0;
    rob.ret_has_rd   = '0;
    rob.ret_is_store = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      rob.ret_pc[k*XLEN +: XLEN]                   = ent_q[win_idx[k]].pc;
      rob.ret_arch_rd[k*ARCH_REG_W +: ARCH_REG_W]  = ent_q[win_idx[k]].arch_rd;
      rob.ret_prd[k*PREG_W +: PREG_W]              = ent_q[win_idx[k]].prd;
      rob.ret_old_prd[k*PREG_W +: PREG_W]          = ent_q[win_idx[k]].old_prd;
      rob.ret_data[k*XLEN +: XLEN]                 = ent_q[win_idx[k]].data;
      rob.ret_has_rd[k]                            = ent_q[win_idx[k]].has_rd;
      rob.ret_is_store[k]                          = ent_q[win_idx[k]].is_store;
    end
  end

  always_comb begin
    head_d = head_q + (ROB_W+1)'(ret_cnt);
    tail_d = tail_q + (ROB_W+1)'(disp_fire);
    if (flush_w) begin
      head_d = head_q;
      tail_d = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done  <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (flush_w) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent_q[i].valid <= 1'b0;
          ent_q[i].done  <= 1'b0;
        end
      end else begin
        // Descending order so the lowest port's write lands last and wins a tag clash.
        for (int p = NUM_CPL-1; p >= 0; p--) begin
          if (rob.cpl_valid[p] && ent_q[rob.cpl_tag[p*ROB_W +: ROB_W]].valid) begin
            ent_q[rob.cpl_tag[p*ROB_W +: ROB_W]].done <= 1'b1;
            ent_q[rob.cpl_tag[p*ROB_W +: ROB_W]].data <= rob.cpl_data[p*XLEN +: XLEN];
          end
        end
        for (int k = 0; k < RETIRE_W; k++) begin
          if (ret_valid[k]) begin
            ent_q[win_idx[k]].valid <= 1'b0;
            ent_q[win_idx[k]].done  <= 1'b0;
          end
        end
        if (disp_fire) begin
          ent_q[tail_q[ROB_W-1:0]].pc       <= rob.disp_pc;
          ent_q[tail_q[ROB_W-1:0]].arch_rd  <= rob.disp_arch_rd;
          ent_q[tail_q[ROB_W-1:0]].prd      <= rob.disp_prd;
          ent_q[tail_q[ROB_W-1:0]].old_prd  <= rob.disp_old_prd;
          ent_q[tail_q[ROB_W-1:0]].has_rd   <= rob.disp_has_rd;
          ent_q[tail_q[ROB_W-1:0]].is_store <= rob.disp_is_store;
          ent_q[tail_q[ROB_W-1:0]].valid    <= 1'b1;
          ent_q[tail_q[ROB_W-1:0]].done     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_ring_buffer.sv
// Directed bench for rob_ring_buffer: out-of-order completion, fill/wrap, port priority,
// store rule, stray completion and (with ROB_FLUSH_EN) flush.
module tb_rob_ring_buffer;

  localparam int DEPTH    = 16;
  localparam int NUM_CPL  = 4;
  localparam int RETIRE_W = 2;
  localparam int PREG_W   = 6;
  localparam int XLEN     = 32;
  localparam int ROB_W    = $clog2(DEPTH);

  logic clk;
  logic rstn;
`ifdef ROB_FLUSH_EN
  logic flush;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q [$];

  rob_ring_buffer_if #(
    .DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .RETIRE_W(RETIRE_W), .PREG_W(PREG_W), .XLEN(XLEN)
  ) rob_if ();

  rob_ring_buffer #(
    .DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .RETIRE_W(RETIRE_W), .PREG_W(PREG_W), .XLEN(XLEN)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .rob  (rob_if)
`ifdef ROB_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every retired slot must match the oldest dispatched PC
  always @(negedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < RETIRE_W; k++) begin
        if (rob_if.ret_valid[k]) begin
          if (exp_q.size() == 0)
            check_eq("ret_pc_unexpected", 64'(rob_if.ret_pc[k*XLEN +: XLEN]), 64'hDEAD_DEAD_DEAD_DEAD);
          else
            check_eq("ret_pc", 64'(rob_if.ret_pc[k*XLEN +: XLEN]), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick();
    tick();
    check_eq("rst_disp_ready", 64'(rob_if.disp_ready), 64'd0);
    check_eq("rst_count",      64'(rob_if.count),      64'd0);
    check_eq("rst_empty",      64'(rob_if.empty),      64'd1);
    check_eq("rst_full",       64'(rob_if.full),       64'd0);
    check_eq("rst_ret_valid",  64'(rob_if.ret_valid),  64'd0);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_eq("post_rst_disp_ready", 64'(rob_if.disp_ready), 64'd1);
  endtask

  task automatic dispatch(input logic [XLEN-1:0] pc, input logic st, input int exp_tag);
    logic fired;
    rob_if.disp_valid    = 1'b1;
    rob_if.disp_pc       = pc;
    rob_if.disp_has_rd   = ~st;
    rob_if.disp_arch_rd  = pc[6:2];
    rob_if.disp_prd      = pc[7:2];
    rob_if.disp_old_prd  = pc[8:3];
    rob_if.disp_is_store = st;
    check_eq("disp_tag", 64'(rob_if.disp_tag), 64'(exp_tag));
    fired = rob_if.disp_ready;
    tick();
    if (fired) exp_q.push_back(pc);
    rob_if.disp_valid = 1'b0;
  endtask

  task automatic cpl_set(input int port, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] data);
    rob_if.cpl_valid[port]                = 1'b1;
    rob_if.cpl_tag[port*ROB_W +: ROB_W]   = tag;
    rob_if.cpl_data[port*XLEN +: XLEN]    = data;
  endtask

  task automatic cpl_clear();
    rob_if.cpl_valid = '0;
  endtask

  task automatic check_ret(input string tag, input logic [RETIRE_W-1:0] exp_valid);
    check_eq(tag, 64'(rob_if.ret_valid), 64'(exp_valid));
  endtask

  initial begin
    rstn = 1'b1;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
    rob_if.disp_valid    = 1'b0;
    rob_if.disp_pc       = '0;
    rob_if.disp_has_rd   = 1'b0;
    rob_if.disp_arch_rd  = '0;
    rob_if.disp_prd      = '0;
    rob_if.disp_old_prd  = '0;
    rob_if.disp_is_store = 1'b0;
    rob_if.cpl_valid     = '0;
    rob_if.cpl_tag       = '0;
    rob_if.cpl_data      = '0;

    // out-of-order completion: tag 2 first, then 0 and 1 together
    do_reset();
    for (int n = 0; n < 3; n++) dispatch(32'h100 + 32'(4*n), 1'b0, n);
    check_eq("ooo_count", 64'(rob_if.count), 64'd3);
    cpl_set(0, 4'd2, 32'h22);
    tick(); cpl_clear();
    check_ret("ooo_no_retire", 2'b00);
    cpl_set(0, 4'd0, 32'h20);
    cpl_set(1, 4'd1, 32'h21);
    tick(); cpl_clear();
    check_ret("ooo_retire_01", 2'b11);
    check_eq("ooo_data0", 64'(rob_if.ret_data[0 +: XLEN]), 64'h20);
    check_eq("ooo_data1", 64'(rob_if.ret_data[XLEN +: XLEN]), 64'h21);
    check_eq("ooo_has_rd", 64'(rob_if.ret_has_rd), 64'b11);
    tick();
    check_ret("ooo_retire_2", 2'b01);
    check_eq("ooo_data2", 64'(rob_if.ret_data[0 +: XLEN]), 64'h22);
    tick();
    check_ret("ooo_idle", 2'b00);
    check_eq("ooo_empty", 64'(rob_if.empty), 64'd1);

    // fill to full, retire tag 0 while dispatch is held, then drain across the wrap
    do_reset();
    for (int n = 0; n < DEPTH; n++) dispatch(32'h200 + 32'(4*n), 1'b0, n);
    check_eq("fill_full", 64'(rob_if.full), 64'd1);
    check_eq("fill_ready", 64'(rob_if.disp_ready), 64'd0);
    check_eq("fill_count", 64'(rob_if.count), 64'd16);
    rob_if.disp_valid = 1'b1;
    rob_if.disp_pc    = 32'h300;
    cpl_set(0, 4'd0, 32'h30);
    tick(); cpl_clear();
    check_ret("fill_ret_tag0", 2'b01);
    check_eq("fill_ready_stall", 64'(rob_if.disp_ready), 64'd0);
    tick();
    check_eq("fill_ready_back", 64'(rob_if.disp_ready), 64'd1);
    check_eq("fill_wrap_tag", 64'(rob_if.disp_tag), 64'd0);
    check_eq("fill_count15", 64'(rob_if.count), 64'd15);
    tick();
    exp_q.push_back(32'h300);
    rob_if.disp_valid = 1'b0;
    check_eq("refill_full", 64'(rob_if.full), 64'd1);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        for (int p = 0; p < NUM_CPL; p++)
          cpl_set(p, ROB_W'(4*c + p + 1), 32'h3000 + 32'(4*c + p + 1));
      end
      tick(); cpl_clear();
      check_ret("drain_pair", 2'b11);
    end
    tick();
    check_ret("drain_idle", 2'b00);
    check_eq("drain_empty", 64'(rob_if.empty), 64'd1);
    check_eq("drain_count", 64'(rob_if.count), 64'd0);

    // two ports complete tag 5 in one cycle: port 0 wins
    do_reset();
    for (int n = 0; n < 6; n++) dispatch(32'h400 + 32'(4*n), 1'b0, n);
    cpl_set(0, 4'd5, 32'hAAAA);
    cpl_set(2, 4'd5, 32'hBBBB);
    cpl_set(1, 4'd0, 32'h40);
    cpl_set(3, 4'd1, 32'h41);
    tick(); cpl_clear();
    check_ret("prio_ret_01", 2'b11);
    check_eq("prio_data0", 64'(rob_if.ret_data[0 +: XLEN]), 64'h40);
    check_eq("prio_data1", 64'(rob_if.ret_data[XLEN +: XLEN]), 64'h41);
    cpl_set(0, 4'd2, 32'h42);
    cpl_set(1, 4'd3, 32'h43);
    cpl_set(2, 4'd4, 32'h44);
    tick(); cpl_clear();
    check_ret("prio_ret_23", 2'b11);
    check_eq("prio_data3", 64'(rob_if.ret_data[XLEN +: XLEN]), 64'h43);
    tick();
    check_ret("prio_ret_45", 2'b11);
    check_eq("prio_data4", 64'(rob_if.ret_data[0 +: XLEN]), 64'h44);
    check_eq("prio_tag5_data", 64'(rob_if.ret_data[XLEN +: XLEN]), 64'hAAAA);
    tick();
    check_eq("prio_empty", 64'(rob_if.empty), 64'd1);

    // two done stores at the head retire one per cycle
    do_reset();
    dispatch(32'h500, 1'b1, 0);
    dispatch(32'h504, 1'b1, 1);
    cpl_set(0, 4'd0, 32'h50);
    cpl_set(1, 4'd1, 32'h51);
    tick(); cpl_clear();
    check_ret("store_first", 2'b01);
    check_eq("store_flag", 64'(rob_if.ret_is_store), 64'b11);
    tick();
    check_ret("store_second", 2'b01);
    tick();
    check_ret("store_idle", 2'b00);
    check_eq("store_empty", 64'(rob_if.empty), 64'd1);

    // completion to an empty slot is dropped; tag 9 must not retire later
    do_reset();
    cpl_set(0, 4'd9, 32'h99);
    tick(); cpl_clear();
    check_eq("stray_count", 64'(rob_if.count), 64'd0);
    check_eq("stray_empty", 64'(rob_if.empty), 64'd1);
    check_ret("stray_ret", 2'b00);
    for (int n = 0; n < 10; n++) dispatch(32'h600 + 32'(4*n), 1'b0, n);
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < NUM_CPL; p++)
        if (4*c + p < 9) cpl_set(p, ROB_W'(4*c + p), 32'h60 + 32'(4*c + p));
      tick(); cpl_clear();
    end
    for (int c = 0; c < 6; c++) tick();
    check_eq("stray_tag9_pending", 64'(rob_if.count), 64'd1);
    check_ret("stray_tag9_not_done", 2'b00);
    check_eq("stray_q_left", 64'(exp_q.size()), 64'd1);

`ifdef ROB_FLUSH_EN
    // flush with 6 in flight, 2 of them done; head sits at index 2
    do_reset();
    dispatch(32'h700, 1'b0, 0);
    dispatch(32'h704, 1'b0, 1);
    cpl_set(0, 4'd0, 32'h70);
    cpl_set(1, 4'd1, 32'h71);
    tick(); cpl_clear();
    tick();
    for (int n = 0; n < 6; n++) dispatch(32'h800 + 32'(4*n), 1'b0, n + 2);
    cpl_set(0, 4'd4, 32'h84);
    cpl_set(1, 4'd5, 32'h85);
    tick(); cpl_clear();
    check_ret("flush_pre_ret", 2'b00);
    check_eq("flush_pre_count", 64'(rob_if.count), 64'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check_eq("flush_count", 64'(rob_if.count), 64'd0);
    check_eq("flush_empty", 64'(rob_if.empty), 64'd1);
    check_ret("flush_ret", 2'b00);
    check_eq("flush_tag", 64'(rob_if.disp_tag), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
